vga_linebuf2: RTL and testbench

Parametrised double-banked (ping-pong) line buffer for the VGA pipeline, the next generation of the single-line save module. The capture side writes one line into a free bank while the display side reads a completed line from the other. Banks swap automatically at line boundaries, with full/empty tracking and an overflow flag. An optional 2x horizontal pixel-repeat read mode is provided. All logic runs in a single clock domain.

---
 rtl/vga_linebuf2.sv | 115 +++++++++++
 tb/tb_vga_linebuf2.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vga_linebuf2.sv
// vga_linebuf2: double-banked (ping-pong) line buffer with 2x pixel-repeat reads
//
// Capture side writes one line into the free bank while the display side reads
// the completed line from the other bank; banks swap at line boundaries.
//
// Ports:
//   iClock      single clock, all logic on posedge
//   RESET       synchronous active-low reset
//   iWrEn       write strobe, one pixel per cycle
//   iData       write pixel
//   iRdEn       read request
//   iRdRestart  rewind the current read line to pixel 0 (beats a same-cycle read)
//   iRepeat     2x horizontal repeat, sampled at the first read of a line
//   iClrErr     clear oOverflow
//   oData       registered read pixel
//   oValid      oData holds a pixel from a read accepted on the previous cycle
//   oRdLast     qualifies the final output of a line
//   oLineReady  current read bank is full
//   oFull       both banks are full
//   oOverflow   sticky: a write was dropped
module vga_linebuf2 #(
    parameter int DATA_W = 16,
    parameter int XSIZE  = 512,
    parameter int AW     = 10
) (
    input  logic              iClock,
    input  logic              RESET,
    input  logic              iWrEn,
    input  logic [DATA_W-1:0] iData,
    input  logic              iRdEn,
    input  logic              iRdRestart,
    input  logic              iRepeat,
    input  logic              iClrErr,
    output logic [DATA_W-1:0] oData,
    output logic              oValid,
    output logic              oRdLast,
    output logic              oLineReady,
    output logic              oFull,
    output logic              oOverflow
);
    localparam logic [AW-1:0] LAST = AW'(XSIZE - 1);

    logic [DATA_W-1:0] mem [0:(2**(AW+1))-1];
    logic [AW-1:0]     wp, rp;
    logic              wb, rb, ph, rq;
    logic [1:0]        full;
    logic              wr_acc, wr_rej, rd_acc, rq_eff, rd_adv, rd_end;

    assign wr_acc = iWrEn && !full[wb];
    assign wr_rej = iWrEn && full[wb];
    assign rd_acc = iRdEn && full[rb] && !iRdRestart;
    // repeat mode is taken live from iRepeat on the first read of a line, then held
    assign rq_eff = (rp == '0 && !ph) ? iRepeat : rq;
    // pointer moves on every read, or on the second output of a repeated pixel
    assign rd_adv = !rq_eff || ph;
    assign rd_end = rd_acc && rp == LAST && rd_adv;

    assign oLineReady = full[rb];
    assign oFull      = &full;

    always_ff @(posedge iClock)
        if (RESET && wr_acc)
            mem[{wb, wp}] <= iData;

    always_ff @(posedge iClock) begin
        if (!RESET) begin
            wp        <= '0;
            rp        <= '0;
            wb        <= 1'b0;
            rb        <= 1'b0;
            ph        <= 1'b0;
            rq        <= 1'b0;
            full      <= 2'b00;
            oData     <= '0;
            oValid    <= 1'b0;
            oRdLast   <= 1'b0;
            oOverflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                if (wp == LAST) begin
                    wp       <= '0;
                    full[wb] <= 1'b1;
                    wb       <= ~wb;
                end else begin
                    wp <= wp + 1'b1;
                end
            end
            if (wr_rej)
                oOverflow <= 1'b1;
            else if (iClrErr)
                oOverflow <= 1'b0;
            oValid  <= rd_acc;
            oRdLast <= rd_end;
            if (rd_acc)
                oData <= mem[{rb, rp}];
            if (iRdRestart) begin
                rp <= '0;
                ph <= 1'b0;
            end else if (rd_acc) begin
                rq <= rq_eff;
                // write and read never touch the same bank, so both full[] updates land
                if (rd_end) begin
                    full[rb] <= 1'b0;
                    rb       <= ~rb;
                    rp       <= '0;
                    ph       <= 1'b0;
                end else begin
                    ph <= rq_eff ? ~ph : 1'b0;
                    if (rd_adv)
                        rp <= rp + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_linebuf2.sv
// tb_vga_linebuf2: directed self-checking bench for vga_linebuf2 with XSIZE = 4
module tb_vga_linebuf2;
    logic        iClock = 1'b0;
    logic        RESET = 1'b0;
    logic        iWrEn = 1'b0;
    logic [15:0] iData = '0;
    logic        iRdEn = 1'b0;
    logic        iRdRestart = 1'b0;
    logic        iRepeat = 1'b0;
    logic        iClrErr = 1'b0;
    logic [15:0] oData;
    logic        oValid, oRdLast, oLineReady, oFull, oOverflow;
    int          checks = 0;
    int          errors = 0;

    vga_linebuf2 #(.DATA_W(16), .XSIZE(4), .AW(2)) dut (
        .iClock(iClock), .RESET(RESET), .iWrEn(iWrEn), .iData(iData),
        .iRdEn(iRdEn), .iRdRestart(iRdRestart), .iRepeat(iRepeat), .iClrErr(iClrErr),
        .oData(oData), .oValid(oValid), .oRdLast(oRdLast), .oLineReady(oLineReady),
        .oFull(oFull), .oOverflow(oOverflow)
    );

    always #5 iClock = ~iClock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge iClock);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " data"}, oData, 0);
        chk({tag, " valid"}, oValid, 0);
        chk({tag, " last"}, oRdLast, 0);
        chk({tag, " ready"}, oLineReady, 0);
        chk({tag, " full"}, oFull, 0);
        chk({tag, " ovf"}, oOverflow, 0);
    endtask

    task automatic wr_line(input logic [15:0] base);
        iWrEn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iData = base + 16'(i);
            tick;
        end
        iWrEn = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] exp_d, input logic exp_last);
        iRdEn = 1'b1;
        tick;
        chk({tag, " valid"}, oValid, 1);
        chk({tag, " data"}, oData, exp_d);
        chk({tag, " last"}, oRdLast, exp_last);
    endtask

    initial begin
        tick;
        tick;
        chk_reset_outputs("reset");
        RESET = 1'b1;

        // basic line
        iWrEn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iData = 16'h10 + 16'(i);
            tick;
            chk("t1 ready", oLineReady, i == 3);
        end
        iWrEn = 1'b0;
        for (int i = 0; i < 4; i++) rd_chk("t1 rd", 16'h10 + 16'(i), i == 3);
        chk("t1 ready fall", oLineReady, 0);
        iRdEn = 1'b0;
        tick;
        chk("t1 idle valid", oValid, 0);

        // ping-pong overlap: read A while writing B, then B with no gap
        wr_line(16'hA0);
        iWrEn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iData = 16'hB0 + 16'(i);
            rd_chk("t2 A", 16'hA0 + 16'(i), i == 3);
            chk("t2 full", oFull, 0);
        end
        iWrEn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_chk("t2 B", 16'hB0 + 16'(i), i == 3);
            chk("t2 full B", oFull, 0);
        end
        iRdEn = 1'b0;

        // overflow
        wr_line(16'h20);
        wr_line(16'h24);
        chk("t3 full", oFull, 1);
        chk("t3 ovf pre", oOverflow, 0);
        iWrEn = 1'b1;
        iData = 16'hFF;
        tick;
        chk("t3 ovf", oOverflow, 1);
        iClrErr = 1'b1;
        tick;
        chk("t3 rej beats clr", oOverflow, 1);
        iWrEn = 1'b0;
        tick;
        chk("t3 clr", oOverflow, 0);
        iClrErr = 1'b0;
        for (int i = 0; i < 8; i++) rd_chk("t3 rd", 16'h20 + 16'(i), i == 3 || i == 7);
        iRdEn = 1'b0;
        tick;
        chk("t3 ready", oLineReady, 0);

        // repeat mode, iRepeat toggled mid-line
        iWrEn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iData = 16'(i + 1);
            tick;
        end
        iWrEn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            iRepeat = (i == 0) || (i > 4);
            rd_chk("t4 rep", 16'(i / 2 + 1), i == 7);
        end
        iRepeat = 1'b0;
        iRdEn = 1'b0;
        tick;
        chk("t4 ready", oLineReady, 0);

        // pause and restart
        wr_line(16'h10);
        rd_chk("t5 p0", 16'h10, 0);
        rd_chk("t5 p1", 16'h11, 0);
        iRdEn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("t5 gap valid", oValid, 0);
            chk("t5 gap hold", oData, 16'h11);
        end
        rd_chk("t5 p2", 16'h12, 0);
        iRdRestart = 1'b1;
        tick;
        chk("t5 restart valid", oValid, 0);
        chk("t5 restart ready", oLineReady, 1);
        iRdRestart = 1'b0;
        for (int i = 0; i < 4; i++) rd_chk("t5 rr", 16'h10 + 16'(i), i == 3);
        iRdEn = 1'b0;

        // empty read, then reset mid-line
        iRdEn = 1'b1;
        tick;
        chk("t6 empty valid", oValid, 0);
        iRdEn = 1'b0;
        iWrEn = 1'b1;
        iData = 16'h30;
        tick;
        iData = 16'h31;
        tick;
        iWrEn = 1'b0;
        RESET = 1'b0;
        tick;
        chk_reset_outputs("t6 reset");
        RESET = 1'b1;
        iWrEn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iData = 16'h40 + 16'(i);
            tick;
            chk("t6 ready", oLineReady, i == 3);
        end
        iWrEn = 1'b0;
        for (int i = 0; i < 4; i++) rd_chk("t6 rd", 16'h40 + 16'(i), i == 3);
        iRdEn = 1'b0;
        tick;
        chk("t6 end ready", oLineReady, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
